fifo_serial_drain: RTL and testbench

Downstream drain stage for the two-entry multi-bit FIFO. Pops one DATA_WIDTH word at a time from the FIFO's zero-latency head (`dout`/`empty`) and shifts it out one bit per accepted beat on a valid/ready serial stream. Back-to-back words are sent with no idle beat between them. Single clock domain, same clock as the FIFO.

---
 rtl/fifo_serial_drain.sv | 169 ++++++++++++++++
 tb/tb_fifo_serial_drain.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serial_drain.sv
// Serial drain stage: pops words from a zero-latency FIFO head and shifts them out
// one bit per accepted valid/ready beat. Define FIFO_SERIAL_DRAIN_PARITY_EN to append an even-parity beat.
module fifo_serial_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    output logic                  ser_dout,
    output logic                  ser_valid,
    input  logic                  ser_ready,
    output logic                  ser_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef FIFO_SERIAL_DRAIN_PARITY_EN
        S_PARITY = 2'd2,
`endif
        S_SHIFT  = 2'd1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic                  ser_dout_q, ser_dout_d;
    logic                  ser_valid_q, ser_valid_d;
    logic                  ser_last_q, ser_last_d;
    logic                  busy_q, busy_d;
    logic                  load_s;
    logic                  fifo_rd_s;
`ifdef FIFO_SERIAL_DRAIN_PARITY_EN
    logic                  par_q, par_d;
`endif

    // Map the transmit index onto the shift-register bit order.
    function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx);
        bit_pos = (MSB_FIRST != 0) ? (LAST_IDX - idx) : idx;
    endfunction

    // Next-state, pop and registered-output computation.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        word_cnt_d = word_cnt_q;
        load_s     = 1'b0;
        fifo_rd_s  = 1'b0;
`ifdef FIFO_SERIAL_DRAIN_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                load_s = !fifo_empty;
            end
            S_SHIFT: begin
                if (ser_ready) begin
`ifdef FIFO_SERIAL_DRAIN_PARITY_EN
                    par_d = par_q ^ shreg_q[bit_pos(bit_idx_q)];
`endif
                    if (bit_idx_q == LAST_IDX) begin
`ifdef FIFO_SERIAL_DRAIN_PARITY_EN
                        state_d = S_PARITY;
`else
                        word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
                        state_d    = S_IDLE;
                        bit_idx_d  = '0;
                        load_s     = !fifo_empty;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    bit_idx_d = bit_idx_q;
                end
            end
`ifdef FIFO_SERIAL_DRAIN_PARITY_EN
            S_PARITY: begin
                if (ser_ready) begin
                    word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
                    state_d    = S_IDLE;
                    bit_idx_d  = '0;
                    load_s     = !fifo_empty;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A reload keeps the FSM in SHIFT so consecutive words have no idle beat.
        if (load_s) begin
            fifo_rd_s = 1'b1;
            shreg_d   = fifo_dout;
            bit_idx_d = '0;
            state_d   = S_SHIFT;
`ifdef FIFO_SERIAL_DRAIN_PARITY_EN
            par_d     = 1'b0;
`endif
        end else begin
            fifo_rd_s = 1'b0;
        end

        ser_valid_d = (state_d != S_IDLE);
        busy_d      = (state_d != S_IDLE);
`ifdef FIFO_SERIAL_DRAIN_PARITY_EN
        ser_last_d  = (state_d == S_PARITY);
`else
        ser_last_d  = (state_d == S_SHIFT) && (bit_idx_d == LAST_IDX);
`endif
        case (state_d)
            S_SHIFT:  ser_dout_d = shreg_d[bit_pos(bit_idx_d)];
`ifdef FIFO_SERIAL_DRAIN_PARITY_EN
            S_PARITY: ser_dout_d = par_d;
`endif
            default:  ser_dout_d = 1'b0;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            word_cnt_q  <= '0;
            ser_dout_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef FIFO_SERIAL_DRAIN_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            word_cnt_q  <= word_cnt_d;
            ser_dout_q  <= ser_dout_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
            busy_q      <= busy_d;
`ifdef FIFO_SERIAL_DRAIN_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign fifo_rd   = fifo_rd_s && !reset;
    assign ser_dout  = ser_dout_q;
    assign ser_valid = ser_valid_q;
    assign ser_last  = ser_last_q;
    assign busy      = busy_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_fifo_serial_drain.sv
// Randomized self-checking bench for fifo_serial_drain: a queue-based FIFO and an
// expected-bit-stream reference model judge every cycle's outputs.
module tb_fifo_serial_drain;

    localparam int DW = 8;
    localparam int CW = 8;
`ifdef FIFO_SERIAL_DRAIN_PARITY_EN
    localparam int FRAME = DW + 1;
`else
    localparam int FRAME = DW;
`endif

    typedef struct {
        logic b;
        logic l;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd;
    logic          ser_dout;
    logic          ser_valid;
    logic          ser_ready = 1'b0;
    logic          ser_last;
    logic          busy;
    logic [CW-1:0] word_cnt;

    logic [DW-1:0] fq[$];
    beat_t         eq[$];
    int            exp_cnt = 0;
    int            checks = 0;
    int            errors = 0;
    logic          acc;
    logic          acc_bit;
    logic          acc_last;
    logic          saw_rd;

    fifo_serial_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .MSB_FIRST(1)) dut (
        .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd(fifo_rd), .ser_dout(ser_dout), .ser_valid(ser_valid),
        .ser_ready(ser_ready), .ser_last(ser_last), .busy(busy), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic rdy, input logic rst);
        logic          exp_rd;
        logic [DW-1:0] w;
        @(negedge clk);
        reset      = rst;
        ser_ready  = rdy;
        fifo_empty = (fq.size() == 0);
        fifo_dout  = fifo_empty ? DW'($urandom) : fq[0];
        #1;
        exp_rd = !rst && !fifo_empty && (eq.size() == 0 || (eq.size() == 1 && rdy));
        checks++;
        if (fifo_rd !== exp_rd) begin
            errors++;
            $display("FAIL fifo_rd: got %b expected %b (t=%0t)", fifo_rd, exp_rd, $time);
        end
        checks++;
        if (ser_valid !== (eq.size() != 0) || busy !== (eq.size() != 0)) begin
            errors++;
            $display("FAIL valid_busy: got %b/%b expected %b (t=%0t)", ser_valid, busy, eq.size() != 0, $time);
        end
        checks++;
        if (word_cnt !== CW'(exp_cnt % 256)) begin
            errors++;
            $display("FAIL word_cnt: got %0d expected %0d (t=%0t)", word_cnt, exp_cnt % 256, $time);
        end
        if (eq.size() != 0) begin
            checks++;
            if (ser_dout !== eq[0].b || ser_last !== eq[0].l) begin
                errors++;
                $display("FAIL stream: got dout=%b last=%b expected dout=%b last=%b (t=%0t)",
                         ser_dout, ser_last, eq[0].b, eq[0].l, $time);
            end
        end else begin
            checks++;
            if (ser_last !== 1'b0) begin
                errors++;
                $display("FAIL idle_last: got %b expected 0 (t=%0t)", ser_last, $time);
            end
        end
        acc = 1'b0;
        if (fifo_rd === 1'b1) begin
            saw_rd = 1'b1;
        end
        if (rst) begin
            eq.delete();
            exp_cnt = 0;
            if (fifo_rd === 1'b1 && fq.size() != 0) begin
                void'(fq.pop_front());
            end
        end else begin
            if (eq.size() != 0 && rdy) begin
                acc      = 1'b1;
                acc_bit  = eq[0].b;
                acc_last = eq[0].l;
                if (eq[0].l) exp_cnt++;
                void'(eq.pop_front());
            end
            if (fifo_rd === 1'b1 && fq.size() != 0) begin
                w = fq.pop_front();
                for (int i = DW - 1; i >= 0; i--) begin
                    eq.push_back('{b: w[i], l: (FRAME == DW) && (i == 0)});
                end
                if (FRAME != DW) eq.push_back('{b: ^w, l: 1'b1});
            end
        end
    endtask

    // Run with random ready until everything is sent; an expired bound is a failure.
    task automatic drain();
        int n = 0;
        while ((eq.size() != 0 || fq.size() != 0) && n < 200) begin
            step(1'($urandom_range(0, 3) != 0), 1'b0);
            n++;
        end
        checks++;
        if (eq.size() != 0 || fq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d bits and %0d words left", eq.size(), fq.size());
        end
        step(1'b1, 1'b0);
    endtask

    // Send one word with a ready pattern, collecting accepted bits in send order.
    task automatic send(input logic [DW-1:0] w, input int pat, output logic [15:0] bits,
                        output int nbeats);
        int i = 0;
        bits   = '0;
        nbeats = 0;
        fq.push_back(w);
        while ((eq.size() != 0 || fq.size() != 0) && i < 100) begin
            if (pat == 0) step(1'b1, 1'b0);
            else          step(1'((i % 4 == 0) || (i % 4 == 3)), 1'b0);
            if (acc) begin
                bits = {bits[14:0], acc_bit};
                nbeats++;
            end
            i++;
        end
        step(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        fq.push_back(8'hA5);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if ({fifo_rd, ser_dout, ser_valid, ser_last, busy} !== 5'b0 || word_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b d=%b v=%b l=%b b=%b cnt=%0d expected all 0",
                     fifo_rd, ser_dout, ser_valid, ser_last, busy, word_cnt);
        end
        step(1'b1, 1'b0);
        checks++;
        if (saw_rd !== 1'b1 || fq.size() != 0) begin
            errors++;
            $display("FAIL reset_first_pop: got fifo_rd=%b expected 1", fifo_rd);
        end
        drain();
    endtask

    task automatic test_single();
        logic [15:0] bits;
        int          n;
        int          c0 = exp_cnt;
        send(8'hA5, 0, bits, n);
        checks++;
        if (n != FRAME || bits[FRAME-1 -: DW] !== 8'hA5 || exp_cnt != c0 + 1) begin
            errors++;
            $display("FAIL single_a5: got %0d beats bits=%h expected %0d beats a5", n, bits, FRAME);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int pops = 0;
        fq.push_back(8'hFF);
        fq.push_back(8'h00);
        step(1'b1, 1'b0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            saw_rd = 1'b0;
            step(1'b1, 1'b0);
            if (saw_rd) pops++;
            if (acc) n++;
        end
        checks++;
        if (n != 2 * FRAME || pops != 1 || eq.size() != 0) begin
            errors++;
            $display("FAIL back_to_back: got %0d beats %0d pops expected %0d beats 1 pop", n, pops, 2 * FRAME);
        end
        step(1'b1, 1'b0);
    endtask

    task automatic test_stall();
        logic [15:0] bits;
        int          n;
        int          c0 = exp_cnt;
        send(8'hC3, 1, bits, n);
        checks++;
        if (n != FRAME || bits[FRAME-1 -: DW] !== 8'hC3 || word_cnt !== CW'(c0 + 1)) begin
            errors++;
            $display("FAIL stall_c3: got %0d beats bits=%h cnt=%0d expected %0d beats c3", n, bits, word_cnt, FRAME);
        end
    endtask

`ifdef FIFO_SERIAL_DRAIN_PARITY_EN
    task automatic test_parity();
        logic [15:0] bits;
        int          n;
        send(8'h07, 0, bits, n);
        checks++;
        if (n != 9 || bits[0] !== 1'b1 || acc_last !== 1'b1) begin
            errors++;
            $display("FAIL parity_07: got %0d beats parity=%b expected 9 beats parity=1", n, bits[0]);
        end
        send(8'h03, 0, bits, n);
        checks++;
        if (n != 9 || bits[0] !== 1'b0) begin
            errors++;
            $display("FAIL parity_03: got %0d beats parity=%b expected 9 beats parity=0", n, bits[0]);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int n = 0;
        int i = 0;
        fq.push_back(8'h5A);
        while (n < 3 && i < 20) begin
            step(1'b1, 1'b0);
            if (acc) n++;
            i++;
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        saw_rd = 1'b0;
        for (int k = 0; k < 12; k++) step(1'($urandom_range(0, 1)), 1'b0);
        checks++;
        if (ser_valid !== 1'b0 || word_cnt !== 8'd0 || saw_rd !== 1'b0 || n != 3) begin
            errors++;
            $display("FAIL reset_mid: got valid=%b cnt=%0d rd_seen=%b expected 0 0 0", ser_valid, word_cnt, saw_rd);
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int i = 0;
        while (sent < 300 && i < 20000) begin
            if (fq.size() < 2 && $urandom_range(0, 2) != 0) begin
                fq.push_back(DW'($urandom));
                sent++;
            end
            step(1'($urandom_range(0, 3) != 0), 1'b0);
            i++;
        end
        drain();
        checks++;
        if (word_cnt !== CW'(300 % 256)) begin
            errors++;
            $display("FAIL random_wrap: got cnt=%0d expected %0d", word_cnt, 300 % 256);
        end
    endtask

    initial begin
        saw_rd = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
`ifdef FIFO_SERIAL_DRAIN_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
